board_scanner: RTL and testbench
================================

BOARD_SCANNER -- requirements
Module: board_scanner

Interface
REQ-001 SHALL have port clk  input  1  single system clock; all state changes on rising edge.
REQ-002 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port new_state  input  1  one-cycle pulse from the game controller; board contents in object memory are final.
REQ-004 SHALL have port next_screen  output  1  one-cycle pulse granting the game controller its next update slot.
REQ-005 SHALL have port frame_start  input  1  one-cycle pulse at the start of each displayed frame (vertical blank).
REQ-006 SHALL have port address_read_om  output  7  read address into object memory, on a read port dedicated to this block.
REQ-007 SHALL have port data_read_om  input  11  object memory read data; [10:8] tile type, [7:0] unused here; valid one cycle after address.
REQ-008 SHALL have port pixel_x  input  10  current pixel column.
REQ-009 SHALL have port pixel_y  input  10  current pixel row.
REQ-010 SHALL have port tile_type  output  3  tile type of the cell under (pixel_x, pixel_y).
REQ-011 SHALL have port busy  output  1  high while in COPY or WAIT_FRAME.
REQ-012 SHALL have parameter GRID, default 10, meaning cells per board row and column (board = GRID*GRID cells, row-major, address = row*GRID + col).
REQ-013 SHALL have parameter TILE_PX, default 48, meaning the pixel edge length of one cell.

Function
REQ-014 SHALL hold two buffers of GRID*GRID 3-bit entries: shadow (written by copy) and display (read by pixel lookup).
REQ-015 SHALL implement states IDLE, COPY, WAIT_FRAME.
REQ-016 IDLE: on frame_start, pulse next_screen for exactly one cycle (next cycle).
REQ-017 IDLE: on new_state, go to COPY and drive address_read_om = 0; new_state and frame_start in the same cycle: next_screen pulses AND enter COPY.
REQ-018 COPY: increment address_read_om by 1 each cycle up to GRID*GRID-1; capture data_read_om[10:8] into shadow[address issued the previous cycle].
REQ-019 COPY: the final capture (cell 99) occurs one cycle after the last address; then go to WAIT_FRAME; COPY lasts exactly GRID*GRID+1 cycles.
REQ-020 WAIT_FRAME: on frame_start, copy shadow into display in one cycle, pulse next_screen once, return to IDLE.
REQ-021 SHALL NOT pulse next_screen while in COPY or WAIT_FRAME except per REQ-020; frame_start in COPY is ignored, display unchanged.
REQ-022 new_state received in COPY or WAIT_FRAME SHALL be ignored (no queuing).
REQ-023 Lookup: col = pixel_x / TILE_PX, row = pixel_y / TILE_PX; tile_type registered, one-cycle latency.
REQ-024 Pixel outside board (pixel_x or pixel_y >= GRID*TILE_PX) SHALL give tile_type = 3'b111.
REQ-025 address_read_om SHALL hold its last value outside COPY.

Reset
REQ-026 Reset SHALL force state IDLE, next_screen 0, busy 0, address_read_om 0, tile_type 0, all shadow and display entries 0.
REQ-027 Reset asserted mid-COPY SHALL abandon the copy; display stays all-zero, no next_screen until the next frame_start after reset release.

Verification
REQ-028 Idle frames: reset, three frame_start pulses 1000 cycles apart -> exactly three next_screen pulses, each one cycle after frame_start; busy stays 0.
REQ-029 Full copy: memory cell k holds type k%8, new_state pulse -> addresses 0..99 on consecutive cycles, busy high, WAIT_FRAME after 101 cycles; next frame_start -> one next_screen, then pixel (50,0) gives type 1 and pixel (0,48) gives type 2 (cell 10) one cycle later.
REQ-030 Blocked frame: frame_start at cycle 40 of COPY -> no next_screen, tile_type of pixel (0,0) unchanged; next frame_start -> next_screen and new data shown.
REQ-031 Collision: new_state and frame_start same cycle in IDLE -> one next_screen, COPY starts; extra new_state during COPY -> ignored, only one copy pass (100 addresses).
REQ-032 Bounds: pixel (479,479) -> cell 99 type; pixel (480,0) and (0,480) -> 3'b111.
REQ-033 Reset mid-copy at cycle 50 -> IDLE, busy 0, all lookups 0, first next_screen follows the first post-reset frame_start.

Source files
------------

// File: rtl/board_scanner_if.sv
// Signal bundle between the board scanner, the game controller/object memory
// and the pixel pipeline.
interface board_scanner_if;
    logic        new_state;
    logic        next_screen;
    logic        frame_start;
    logic [6:0]  address_read_om;
    logic [10:0] data_read_om;
    logic [9:0]  pixel_x;
    logic [9:0]  pixel_y;
    logic [2:0]  tile_type;
    logic        busy;

    modport master (
        output new_state, frame_start, data_read_om, pixel_x, pixel_y,
        input  next_screen, address_read_om, tile_type, busy
    );

    modport slave (
        input  new_state, frame_start, data_read_om, pixel_x, pixel_y,
        output next_screen, address_read_om, tile_type, busy
    );
endinterface

// File: rtl/board_scanner.sv
// Copies the game board from object memory into a shadow buffer, swaps it into
// the display buffer at vertical blank, and looks up the tile under the pixel.
module board_scanner #(
    parameter int GRID    = 10,
    parameter int TILE_PX = 48
) (
    input  logic            clk,
    input  logic            reset,
    board_scanner_if.slave  bus
);
    localparam int         CELLS     = GRID * GRID;
    localparam logic [6:0] LAST_ADDR = 7'(CELLS - 1);
    localparam logic [6:0] COPY_END  = 7'(CELLS);
    localparam logic [6:0] GRID_W    = 7'(GRID);
    localparam logic [9:0] TILE_W    = 10'(TILE_PX);
    localparam logic [9:0] EDGE_W    = 10'(GRID * TILE_PX);

    typedef enum logic [1:0] {IDLE, COPY, WAIT_FRAME} state_t;

    state_t      state_reg, state_next;
    logic [6:0]  addr_reg;
    logic [6:0]  cnt_reg;
    logic        next_screen_reg;
    logic [2:0]  tile_type_reg;
    logic [2:0]  shadow_reg  [CELLS];
    logic [2:0]  display_reg [CELLS];

    logic        start_copy;
    logic        capture_en;
    logic        load_display;
    logic        pulse_next;
    logic [6:0]  capture_idx;
    logic [6:0]  row_idx;
    logic [6:0]  col_idx;
    logic [6:0]  cell_idx;
    logic        in_board;
    logic [2:0]  lookup_val;
    logic [7:0]  unused_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        start_copy   = 1'b0;
        capture_en   = 1'b0;
        load_display = 1'b0;
        pulse_next   = 1'b0;
        case (state_reg)
            IDLE: begin
                pulse_next = bus.frame_start;
                if (bus.new_state) begin
                    start_copy = 1'b1;
                    state_next = COPY;
                end
            end
            COPY: begin
                // Read data trails the address by a cycle, so cycle 0 has nothing to capture.
                capture_en = (cnt_reg != 7'd0);
                if (cnt_reg == COPY_END) begin
                    state_next = WAIT_FRAME;
                end
            end
            WAIT_FRAME: begin
                if (bus.frame_start) begin
                    load_display = 1'b1;
                    pulse_next   = 1'b1;
                    state_next   = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign capture_idx = cnt_reg - 7'd1;

    assign row_idx    = 7'(bus.pixel_y / TILE_W);
    assign col_idx    = 7'(bus.pixel_x / TILE_W);
    assign cell_idx   = row_idx * GRID_W + col_idx;
    assign in_board   = (bus.pixel_x < EDGE_W) && (bus.pixel_y < EDGE_W);
    assign lookup_val = in_board ? display_reg[cell_idx] : 3'b111;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_reg        <= 7'd0;
            cnt_reg         <= 7'd0;
            next_screen_reg <= 1'b0;
            tile_type_reg   <= 3'd0;
            for (int i = 0; i < CELLS; i++) begin
                shadow_reg[i]  <= 3'd0;
                display_reg[i] <= 3'd0;
            end
        end else begin
            next_screen_reg <= pulse_next;
            tile_type_reg   <= lookup_val;
            if (start_copy) begin
                addr_reg <= 7'd0;
                cnt_reg  <= 7'd0;
            end else if (state_reg == COPY) begin
                cnt_reg <= cnt_reg + 7'd1;
                if (addr_reg != LAST_ADDR) begin
                    addr_reg <= addr_reg + 7'd1;
                end
            end
            if (capture_en) begin
                shadow_reg[capture_idx] <= bus.data_read_om[10:8];
            end
            if (load_display) begin
                for (int i = 0; i < CELLS; i++) begin
                    display_reg[i] <= shadow_reg[i];
                end
            end
        end
    end

    assign unused_data         = bus.data_read_om[7:0];
    assign bus.next_screen     = next_screen_reg;
    assign bus.address_read_om = addr_reg;
    assign bus.tile_type       = tile_type_reg;
    assign bus.busy            = (state_reg != IDLE);

endmodule

// File: tb/tb_board_scanner.sv
// Scoreboard bench for board_scanner: stimulus pushes expectations derived from
// a cycle-level behavioural model, a negedge monitor pops and compares them.
module tb_board_scanner;
    localparam int GRID  = 10;
    localparam int TILE  = 48;
    localparam int CELLS = GRID * GRID;
    localparam int EDGE  = GRID * TILE;

    localparam int K_TILE = 0;
    localparam int K_ADDR = 1;
    localparam int K_BUSY = 2;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    board_scanner_if bus();

    board_scanner #(.GRID(GRID), .TILE_PX(TILE)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Object memory: registered read, data one cycle after the address.
    logic [10:0] mem [128];
    always @(posedge clk) bus.data_read_om <= mem[bus.address_read_om];

    typedef struct {
        int    at;
        int    kind;
        int    value;
        string name;
    } probe_t;

    probe_t probes[$];
    int     exp_ns[$];
    int     checks = 0;
    int     passed = 0;

    // Behavioural model: board snapshots plus the cycle at which a copy began.
    int         m_copying  = 0;
    int         copy_start = 0;
    logic [2:0] m_shadow  [CELLS];
    logic [2:0] m_display [CELLS];

    // 0 = idle, 1 = copying (CELLS+1 cycles from copy_start), 2 = waiting for frame
    function automatic int eff_phase(input int c);
        if (m_copying == 0) return 0;
        if (c > copy_start + CELLS) return 2;
        return 1;
    endfunction

    function automatic int expected_tile(input int px, input int py);
        if (px >= EDGE || py >= EDGE) return 7;
        return int'(m_display[(py / TILE) * GRID + (px / TILE)]);
    endfunction

    function automatic void push_probe(input int at, input int kind, input int value, input string name);
        probe_t p;
        p.at = at; p.kind = kind; p.value = value; p.name = name;
        probes.push_back(p);
    endfunction

    always @(negedge clk) begin
        bit e;
        int act;
        e = (exp_ns.size() > 0) && (exp_ns[0] == cyc);
        if (e) void'(exp_ns.pop_front());
        if (e || bus.next_screen) begin
            checks++;
            if (bus.next_screen === e) passed++;
            else $display("FAIL next_screen cyc=%0d got=%0b expected=%0b", cyc, bus.next_screen, e);
        end
        for (int i = probes.size() - 1; i >= 0; i--) begin
            if (probes[i].at == cyc) begin
                case (probes[i].kind)
                    K_TILE:  act = int'(bus.tile_type);
                    K_ADDR:  act = int'(bus.address_read_om);
                    default: act = int'(bus.busy);
                endcase
                checks++;
                if (act == probes[i].value) passed++;
                else $display("FAIL %s cyc=%0d got=%0d expected=%0d", probes[i].name, cyc, act, probes[i].value);
                probes.delete(i);
            end
        end
    end

    // One clock of stimulus; the lookup is modelled before any frame swap of the same cycle.
    task automatic cycle_in(input bit ns, input bit fs, input bit probe, input int px, input int py);
        int c;
        int ph;
        @(negedge clk);
        c = cyc;
        bus.new_state   = ns;
        bus.frame_start = fs;
        if (probe) begin
            bus.pixel_x = 10'(px);
            bus.pixel_y = 10'(py);
            push_probe(c + 1, K_TILE, expected_tile(px, py), "tile_type");
        end
        ph = eff_phase(c);
        if (fs && ph != 1) begin
            exp_ns.push_back(c + 1);
            push_probe(c + 1, K_BUSY, (ns && ph == 0) ? 1 : 0, "busy_after_frame");
            if (ph == 2) begin
                m_display = m_shadow;
                m_copying = 0;
            end
            $display("txn cyc=%0d frame_start accepted (phase %0d)", c, ph);
        end
        if (ns && ph == 0) begin
            m_copying  = 1;
            copy_start = c + 1;
            for (int k = 0; k < CELLS; k++) begin
                m_shadow[k] = mem[k][10:8];
                push_probe(c + 1 + k, K_ADDR, k, "address_read_om");
            end
            push_probe(c + 1 + CELLS, K_ADDR, CELLS - 1, "address_last");
            push_probe(c + 1, K_BUSY, 1, "busy_copy_first");
            push_probe(c + 1 + CELLS, K_BUSY, 1, "busy_copy_last");
            push_probe(c + 2 + CELLS, K_BUSY, 1, "busy_wait_frame");
            $display("txn cyc=%0d new_state accepted, copy starts", c);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) cycle_in(1'b0, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic probe_px(input int px, input int py);
        cycle_in(1'b0, 1'b0, 1'b1, px, py);
    endtask

    task automatic probe_random(input int n);
        repeat (n) probe_px(int'($urandom_range(0, 560)), int'($urandom_range(0, 560)));
    endtask

    task automatic load_random_mem();
        for (int k = 0; k < 128; k++) mem[k] = 11'($urandom);
    endtask

    task automatic apply_reset();
        int c;
        @(negedge clk);
        #1;
        c = cyc;
        reset           = 1'b1;
        bus.new_state   = 1'b0;
        bus.frame_start = 1'b0;
        bus.pixel_x     = 10'd1000;
        bus.pixel_y     = 10'd0;
        m_copying = 0;
        for (int k = 0; k < CELLS; k++) m_display[k] = 3'd0;
        for (int i = probes.size() - 1; i >= 0; i--) if (probes[i].at > c) probes.delete(i);
        for (int i = exp_ns.size() - 1; i >= 0; i--) if (exp_ns[i] > c) exp_ns.delete(i);
        push_probe(c + 1, K_TILE, 0, "reset_tile_type");
        push_probe(c + 1, K_ADDR, 0, "reset_address");
        push_probe(c + 1, K_BUSY, 0, "reset_busy");
        $display("txn cyc=%0d reset asserted", c);
        repeat (3) @(negedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d got=running expected=finished", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        bus.new_state   = 1'b0;
        bus.frame_start = 1'b0;
        bus.pixel_x     = 10'd0;
        bus.pixel_y     = 10'd0;
        for (int k = 0; k < 128; k++) mem[k] = 11'd0;
        for (int k = 0; k < CELLS; k++) begin
            m_shadow[k]  = 3'd0;
            m_display[k] = 3'd0;
        end

        apply_reset();
        idle(2);

        // Idle frames
        for (int i = 0; i < 3; i++) begin
            cycle_in(1'b0, 1'b1, 1'b0, 0, 0);
            idle(999);
        end

        // Full copy of cell k = k % 8
        for (int k = 0; k < 128; k++) mem[k] = {3'(k % 8), 8'($urandom)};
        cycle_in(1'b1, 1'b0, 1'b0, 0, 0);
        idle(105);
        cycle_in(1'b0, 1'b1, 1'b0, 0, 0);
        probe_px(50, 0);
        probe_px(0, 48);
        probe_px(479, 479);
        probe_px(480, 0);
        probe_px(0, 480);
        probe_random(10);

        // Frame during copy is ignored
        load_random_mem();
        cycle_in(1'b1, 1'b0, 1'b0, 0, 0);
        idle(39);
        cycle_in(1'b0, 1'b1, 1'b1, 0, 0);
        idle(70);
        probe_px(0, 0);
        cycle_in(1'b0, 1'b1, 1'b0, 0, 0);
        probe_px(0, 0);
        probe_random(10);

        // Collision in idle, then a redundant new_state mid-copy
        load_random_mem();
        cycle_in(1'b1, 1'b1, 1'b0, 0, 0);
        idle(29);
        cycle_in(1'b1, 1'b0, 1'b0, 0, 0);
        idle(80);
        cycle_in(1'b0, 1'b1, 1'b0, 0, 0);
        probe_random(15);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            if (m_copying == 0 && $urandom_range(0, 19) == 0) load_random_mem();
            cycle_in($urandom_range(0, 39) == 0, $urandom_range(0, 59) == 0,
                     $urandom_range(0, 1) == 0,
                     int'($urandom_range(0, 560)), int'($urandom_range(0, 560)));
        end
        idle(110);
        cycle_in(1'b0, 1'b1, 1'b0, 0, 0);
        idle(2);

        // Reset in the middle of a copy
        load_random_mem();
        cycle_in(1'b1, 1'b0, 1'b0, 0, 0);
        idle(49);
        apply_reset();
        idle(150);
        probe_random(10);
        probe_px(479, 479);
        cycle_in(1'b0, 1'b1, 1'b0, 0, 0);
        probe_random(5);
        idle(5);

        checks++;
        if (probes.size() == 0 && exp_ns.size() == 0) passed++;
        else $display("FAIL drain got=%0d/%0d pending expected=0/0", probes.size(), exp_ns.size());

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
